// File: rtl/cp0_pkg.sv
// ---------------------------------------------------------------------------
// cp0_pkg : ExcCodes, handler address, scheduler states, exception priority
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cp0_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } sched_state_e;

  // Earliest pipeline stage wins; code 0 on a stage means "nothing detected".
  function automatic logic [4:0] exc_select(input logic [4:0] f, input logic [4:0] d,
                                            input logic [4:0] e, input logic [4:0] m);
    if (f != EXC_INT) return f;
    if (d != EXC_INT) return d;
    if (e != EXC_INT) return e;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_sched_if.sv
// ---------------------------------------------------------------------------
// exc_sched_if : pipeline / CP0 / device signals around the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface exc_sched_if #(
  parameter int NUM_IRQ = 6
);
  logic               m_valid;
  logic [31:0]        m_pc;
  logic               m_bd;
  logic [4:0]         f_exc;
  logic [4:0]         d_exc;
  logic [4:0]         e_exc;
  logic [4:0]         m_exc;
  logic               m_eret;
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               cp0_req;
  logic [31:0]        cp0_epc;

  logic [4:0]         cp0_exc_code;
  logic               cp0_bd;
  logic [31:0]        cp0_vpc;
  logic [NUM_IRQ-1:0] cp0_hwint;
  logic               cp0_exl_clr;
  logic               flush;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;

  modport master (
    output m_valid, m_pc, m_bd, f_exc, d_exc, e_exc, m_exc, m_eret,
           irq_in, irq_edge, irq_ack, cp0_req, cp0_epc,
    input  cp0_exc_code, cp0_bd, cp0_vpc, cp0_hwint, cp0_exl_clr,
           flush, stall, redirect, redirect_pc
  );

  modport slave (
    input  m_valid, m_pc, m_bd, f_exc, d_exc, e_exc, m_exc, m_eret,
           irq_in, irq_edge, irq_ack, cp0_req, cp0_epc,
    output cp0_exc_code, cp0_bd, cp0_vpc, cp0_hwint, cp0_exl_clr,
           flush, stall, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/exc_sched_irq_pending.sv
// ---------------------------------------------------------------------------
// irq_pending : IRQ sample + edge/level pending with ack (IRQ_SYNC_EN adds 2-flop sync)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_pending #(
  parameter int NUM_IRQ = 6
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [NUM_IRQ-1:0] irq_in_i,
  input  wire logic [NUM_IRQ-1:0] irq_edge_i,
  input  wire logic [NUM_IRQ-1:0] irq_ack_i,
  output logic      [NUM_IRQ-1:0] pending_o
);

  logic [NUM_IRQ-1:0] samp_d;
  logic [NUM_IRQ-1:0] samp_q;
  logic [NUM_IRQ-1:0] edge_pend_d;
  logic [NUM_IRQ-1:0] edge_pend_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign samp_d = sync2_q;
`else
  assign samp_d = irq_in_i;
`endif

  // Rising edge is judged on the value entering samp, so set and ack land
  // on the same clock edge and set takes priority.
  always_comb begin
    edge_pend_d = (edge_pend_q & ~irq_ack_i) | (samp_d & ~samp_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      samp_q      <= samp_d;
      edge_pend_q <= edge_pend_d;
    end
  end

  assign pending_o = (irq_edge_i & edge_pend_q) | (~irq_edge_i & samp_q);

endmodule

`default_nettype wire

// File: rtl/exc_sched.sv
// ---------------------------------------------------------------------------
// exc_sched : exception/IRQ gating to CP0 and flush/redirect sequencing
// Optional macro IRQ_SYNC_EN (synchronize irq_in). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_sched
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          NUM_IRQ      = 6
) (
  input wire logic  clk,
  input wire logic  reset,
  exc_sched_if.slave bus
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  sched_state_e       state_q;
  logic [3:0]         cnt_q;
  logic [31:0]        target_q;
  logic               flush_q;
  logic               stall_q;
  logic               redirect_q;

  logic [NUM_IRQ-1:0] pending;
  logic [4:0]         exc_sel;
  logic               present;
  logic               eret_ok;

  irq_pending #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_pending (
    .clk        (clk),
    .reset      (reset),
    .irq_in_i   (bus.irq_in),
    .irq_edge_i (bus.irq_edge),
    .irq_ack_i  (bus.irq_ack),
    .pending_o  (pending)
  );

  assign exc_sel = exc_select(bus.f_exc, bus.d_exc, bus.e_exc, bus.m_exc);

  // CP0 only sees exceptions/interrupts against a real M instruction while idle.
  assign present = reset && (state_q == ST_IDLE) && bus.m_valid;
  assign eret_ok = present && bus.m_eret && (exc_sel == EXC_INT) && !bus.cp0_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= HANDLER_PC;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cp0_req || eret_ok) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= FLUSH_INIT;
            target_q <= bus.cp0_req ? HANDLER_PC : bus.cp0_epc;
            flush_q  <= 1'b1;
            stall_q  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_q    <= ST_REDIRECT;
            flush_q    <= 1'b0;
            redirect_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_REDIRECT: begin
          state_q    <= ST_IDLE;
          redirect_q <= 1'b0;
          stall_q    <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          flush_q    <= 1'b0;
          stall_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cp0_exc_code = present ? exc_sel : 5'd0;
  assign bus.cp0_bd       = present && bus.m_bd;
  assign bus.cp0_vpc      = reset ? bus.m_pc : 32'd0;
  assign bus.cp0_hwint    = present ? pending : '0;
  assign bus.cp0_exl_clr  = eret_ok;
  assign bus.flush        = flush_q;
  assign bus.stall        = stall_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = target_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_sched.sv
// ---------------------------------------------------------------------------
// tb_exc_sched : directed + randomized bench with a behavioural scheduler model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_exc_sched;
  import cp0_pkg::*;

  localparam int          NI  = 6;
  localparam int          FC  = 2;
  localparam logic [31:0] HPC = 32'h0000_4180;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  exc_sched_if #(.NUM_IRQ(NI)) bus();

  exc_sched #(
    .HANDLER_PC   (HPC),
    .FLUSH_CYCLES (FC),
    .NUM_IRQ      (NI)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // seq: 0 = idle, 1..FC = flushing, FC+1 = redirect cycle
  int          seq = 0;
  logic [31:0] mdl_target;
  logic [NI-1:0] hist [0:3];
  logic [NI-1:0] mdl_epend;
  bit          started = 0;

  function automatic logic [4:0] pick_exc();
    logic [4:0] codes [0:3];
    codes[0] = bus.f_exc; codes[1] = bus.d_exc; codes[2] = bus.e_exc; codes[3] = bus.m_exc;
    for (int k = 0; k < 4; k++) if (codes[k] != 5'd0) return codes[k];
    return 5'd0;
  endfunction

  function automatic logic [NI-1:0] mdl_pending();
    logic [NI-1:0] p;
    for (int l = 0; l < NI; l++) p[l] = bus.irq_edge[l] ? mdl_epend[l] : hist[LAT-1][l];
    return p;
  endfunction

  function automatic bit mdl_present();
    return reset && seq == 0 && bus.m_valid;
  endfunction

  function automatic bit mdl_eret_ok();
    return mdl_present() && bus.m_eret && pick_exc() == 5'd0 && !bus.cp0_req;
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      seq = 0;
      mdl_target = HPC;
      mdl_epend = '0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
    end else begin
      if (seq == 0) begin
        if (bus.cp0_req) begin
          seq = 1; mdl_target = HPC;
        end else if (mdl_eret_ok()) begin
          seq = 1; mdl_target = bus.cp0_epc;
        end
      end else if (seq == FC + 1) begin
        seq = 0;
      end else begin
        seq++;
      end
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = bus.irq_in;
      for (int l = 0; l < NI; l++) begin
        if (hist[LAT-1][l] && !hist[LAT][l]) mdl_epend[l] = 1'b1;
        else if (bus.irq_ack[l])             mdl_epend[l] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit g;
  always @(negedge clk) begin
    if (started) begin
      g = mdl_present();
      chk("exc_code", 32'(bus.cp0_exc_code), g ? 32'(pick_exc()) : 32'd0);
      chk("bd",       32'(bus.cp0_bd),       32'(g && bus.m_bd));
      chk("vpc",      bus.cp0_vpc,           reset ? bus.m_pc : 32'd0);
      chk("hwint",    32'(bus.cp0_hwint),    g ? 32'(mdl_pending()) : 32'd0);
      chk("exl_clr",  32'(bus.cp0_exl_clr),  32'(mdl_eret_ok()));
      chk("flush",    32'(bus.flush),        32'(seq >= 1 && seq <= FC));
      chk("stall",    32'(bus.stall),        32'(seq != 0));
      chk("redirect", 32'(bus.redirect),     32'(seq == FC + 1));
      chk("redir_pc", bus.redirect_pc,       mdl_target);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m_valid = 0; bus.m_pc = 32'h0; bus.m_bd = 0;
    bus.f_exc = 0; bus.d_exc = 0; bus.e_exc = 0; bus.m_exc = 0;
    bus.m_eret = 0; bus.irq_ack = '0; bus.cp0_req = 0; bus.cp0_epc = 32'h0;
  endtask

  function automatic logic [4:0] rand_code();
    case ($urandom_range(0, 11))
      0: return EXC_ADEL;
      1: return EXC_ADES;
      2: return EXC_SYSCALL;
      3: return EXC_RI;
      4: return EXC_OV;
      default: return EXC_INT;
    endcase
  endfunction

  task automatic rand_inputs();
    bus.m_valid = ($urandom_range(0, 3) != 0);
    bus.m_pc    = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
    bus.m_bd    = 1'($urandom_range(0, 1));
    bus.f_exc   = rand_code();
    bus.d_exc   = rand_code();
    bus.e_exc   = rand_code();
    bus.m_exc   = rand_code();
    bus.m_eret  = ($urandom_range(0, 4) == 0);
    for (int i = 0; i < NI; i++) begin
      if ($urandom_range(0, 5) == 0) bus.irq_in[i] = ~bus.irq_in[i];
      bus.irq_ack[i] = ($urandom_range(0, 3) == 0);
    end
    bus.cp0_req = ($urandom_range(0, 9) == 0);
    bus.cp0_epc = $urandom;
    reset       = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    clear_inputs();
    bus.irq_in   = '0;
    bus.irq_edge = 6'b000100;
    reset = 0;
    tick(); tick();
    at_neg();
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_redir", 32'(bus.redirect), 32'd0);
    chk("rst_rpc",   bus.redirect_pc, 32'h0000_4180);

    // exception priority and handler entry
    tick();
    reset = 1;
    bus.m_valid = 1; bus.f_exc = 5'd4; bus.e_exc = 5'd12;
    bus.m_pc = 32'h3010; bus.m_bd = 1; bus.cp0_req = 1;
    at_neg();
    chk("prio_code", 32'(bus.cp0_exc_code), 32'd4);
    chk("prio_bd",   32'(bus.cp0_bd), 32'd1);
    chk("prio_vpc",  bus.cp0_vpc, 32'h3010);
    tick(); clear_inputs();
    at_neg(); chk("exc_flush1", 32'(bus.flush), 32'd1);
    tick(); at_neg(); chk("exc_flush2", 32'(bus.flush), 32'd1);
    tick(); at_neg();
    chk("exc_redir", 32'(bus.redirect), 32'd1);
    chk("exc_rpc",   bus.redirect_pc, 32'h4180);
    tick(); at_neg(); chk("exc_done", 32'(bus.stall), 32'd0);

    // interrupt held while M holds bubbles
    tick(); bus.irq_in[2] = 1'b1;
    at_neg(); chk("bub_hw0", 32'(bus.cp0_hwint), 32'd0);
    tick(); bus.irq_in[2] = 1'b0;
    for (int c = 0; c < 2 + LAT; c++) begin
      at_neg(); chk("bub_hw", 32'(bus.cp0_hwint), 32'd0);
      tick();
    end
    bus.m_valid = 1;
    at_neg(); chk("bub_first", 32'(bus.cp0_hwint), 32'h04);

    // ack racing a new edge, then ack alone
    tick(); bus.irq_in[2] = 1'b1;
    for (int c = 0; c < LAT - 1; c++) tick();
    bus.irq_ack[2] = 1'b1;
    tick(); bus.irq_ack = '0;
    at_neg(); chk("ack_race", 32'(bus.cp0_hwint), 32'h04);
    tick(); bus.irq_ack[2] = 1'b1;
    tick(); bus.irq_ack = '0;
    at_neg(); chk("ack_clr", 32'(bus.cp0_hwint), 32'h00);

    // ERET to EPC
    tick(); clear_inputs(); bus.irq_in = '0;
    bus.m_valid = 1; bus.m_eret = 1; bus.cp0_epc = 32'h3024;
    at_neg(); chk("eret_clr", 32'(bus.cp0_exl_clr), 32'd1);
    tick(); clear_inputs();
    at_neg(); chk("eret_clr_off", 32'(bus.cp0_exl_clr), 32'd0);
    tick(); at_neg();
    tick(); at_neg();
    chk("eret_redir", 32'(bus.redirect), 32'd1);
    chk("eret_rpc",   bus.redirect_pc, 32'h3024);

    // ERET faulting in decode goes to the handler instead
    tick();
    bus.m_valid = 1; bus.m_eret = 1; bus.d_exc = 5'd10; bus.cp0_epc = 32'h3024; bus.cp0_req = 1;
    at_neg();
    chk("eretx_clr",  32'(bus.cp0_exl_clr), 32'd0);
    chk("eretx_code", 32'(bus.cp0_exc_code), 32'd10);
    tick(); clear_inputs();
    tick(); tick(); at_neg();
    chk("eretx_redir", 32'(bus.redirect), 32'd1);
    chk("eretx_rpc",   bus.redirect_pc, 32'h4180);

    // reset aborts a sequence in progress
    tick();
    bus.m_valid = 1; bus.m_eret = 1; bus.cp0_epc = 32'h3aa0;
    tick(); clear_inputs();
    tick(); reset = 0;
    tick(); tick();
    at_neg();
    chk("mid_rst_flush", 32'(bus.flush), 32'd0);
    chk("mid_rst_redir", 32'(bus.redirect), 32'd0);
    chk("mid_rst_rpc",   bus.redirect_pc, 32'h4180);
    tick(); reset = 1;
    at_neg(); chk("mid_rst_idle", 32'(bus.stall), 32'd0);
    tick(); at_neg(); chk("mid_rst_noredir", 32'(bus.redirect), 32'd0);

    // randomized phase, new line configuration applied under reset
    tick();
    bus.irq_edge = NI'($urandom);
    reset = 0;
    tick(); tick();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      tick();
    end
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_sched.md
Name: exc_sched

Overview:
- Exception/interrupt scheduler in front of the CP0 register block.
- Merges per-stage exception codes for the instruction in M and captures device interrupt lines into a pending register.
- Presents interrupts to CP0 only when M holds a real instruction.
- On a CP0 request or ERET, sequences pipeline flush and PC redirect (handler entry or EPC return).

Parameters:
HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address
FLUSH_CYCLES, 2, cycles flush is held before redirect (1..15)
NUM_IRQ, 6, device interrupt lines (matches CP0 HWInt width)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
m_valid  in  1  M stage holds a real instruction, not a bubble
m_pc  in  32  PC of M-stage instruction
m_bd  in  1  M instruction sits in a delay slot
f_exc  in  5  fetch-detected ExcCode carried to M (0 = none)
d_exc  in  5  decode-detected ExcCode (0 = none)
e_exc  in  5  execute-detected ExcCode (0 = none)
m_exc  in  5  memory-detected ExcCode (0 = none)
m_eret  in  1  M instruction is ERET
irq_in  in  NUM_IRQ  raw device interrupt lines
irq_edge  in  NUM_IRQ  per line: 1 = edge-triggered, 0 = level
irq_ack  in  NUM_IRQ  one-cycle pulse clears the edge-pending bit
cp0_req  in  1  CP0 Req (exception/interrupt taken this cycle)
cp0_epc  in  32  CP0 EPC output
cp0_exc_code  out  5  ExcCode to CP0
cp0_bd  out  1  BD to CP0
cp0_vpc  out  32  VPC to CP0
cp0_hwint  out  NUM_IRQ  HWInt to CP0
cp0_exl_clr  out  1  EXLClr to CP0
flush  out  1  kill all in-flight instructions F..M
stall  out  1  freeze PC/fetch
redirect  out  1  one-cycle PC load strobe
redirect_pc  out  32  PC to load on redirect

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, counter=0, pending=0, sample regs=0. All outputs 0, except redirect_pc=HANDLER_PC. Reset mid-sequence aborts it; no redirect is issued.
- IRQ capture:
  - irq_in is registered once into samp.
  - Level line: pending[i]=samp[i].
  - Edge line: pending[i] sets on samp[i] 0->1 relative to the previous sample, and clears on irq_ack[i]. If set and ack occur in the same cycle, set wins.
  - irq_ack on a level line is ignored.
- Exception select (combinational): first nonzero of f_exc, d_exc, e_exc, m_exc, in that priority order.
- CP0 gating:
  - In IDLE with m_valid=1: cp0_exc_code=selected code; cp0_vpc=m_pc; cp0_bd=m_bd; cp0_hwint=pending.
  - Otherwise: cp0_exc_code=0, cp0_hwint=0, cp0_bd=0, cp0_vpc=m_pc. Pending is held internally, so an interrupt waits for a valid instruction and is never lost.
- ERET accept: in IDLE with m_valid=1, m_eret=1, selected code=0 and cp0_req=0:
  - cp0_exl_clr=1 for that cycle.
  - cp0_epc is latched as the redirect target.
  - FSM goes to FLUSH.
- An exception on the ERET itself takes precedence; exl_clr stays 0.
- FSM states and transitions:
  - IDLE: cp0_req=1 -> latch target=HANDLER_PC, go to FLUSH with counter=FLUSH_CYCLES-1. ERET accept -> same, with target=cp0_epc.
  - FLUSH: flush=1, stall=1; counter decrements; at 0 go to REDIRECT.
  - REDIRECT: redirect=1, redirect_pc=target, stall=1, flush=0; next state IDLE.
- Minimum sequence length is FLUSH_CYCLES+1 cycles. cp0_req and ERET inputs are ignored outside IDLE.
- redirect_pc holds its last target when redirect=0.

Optional Feature:
IRQ_SYNC_EN:
- Defined: irq_in passes through a two-flop synchronizer before samp. Input-to-pending latency is 3 cycles.
- Undefined: single register; latency is 1 cycle, and irq_in is assumed synchronous to clk.

Decomposition:
- Shared package cp0_pkg:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12.
  - HANDLER_PC default.
  - FSM state enum {IDLE, FLUSH, REDIRECT}.
- One sub-module, irq_pending: synchronizer (under IRQ_SYNC_EN), sample register, and edge/level pending logic with ack. Parameterized by NUM_IRQ.

Test Plan:
- Reset: drive reset=0 for 2 cycles mid-FLUSH -> flush=0, redirect=0, pending=0, state IDLE next cycle.
- Exception priority: m_valid=1, f_exc=4, e_exc=12, m_pc=32'h3010, m_bd=1 -> cp0_exc_code=4, cp0_bd=1, cp0_vpc=32'h3010. With cp0_req=1, expect flush for 2 cycles, then redirect=1 with redirect_pc=32'h4180.
- Bubble deferral: edge irq_in[2] pulses while m_valid=0 for 3 cycles -> cp0_hwint=0 throughout; first m_valid=1 cycle -> cp0_hwint=6'b000100.
- Pending ack: irq_ack[2] in the same cycle as a new rising edge on line 2 -> pending[2] stays 1. Ack alone -> pending[2]=0 next cycle.
- ERET: m_valid=1, m_eret=1, no exception, cp0_epc=32'h3024 -> cp0_exl_clr=1 for one cycle, then redirect_pc=32'h3024 after the flush cycles.
- ERET with d_exc=10 -> cp0_exl_clr=0, cp0_exc_code=10; redirect goes to 32'h4180.
